ay_video_timing: RTL
====================

// Module: ay_video_timing
// PURPOSE
// - PAL 15 kHz raster generator and colour mixer that sits directly upstream of the scandoubler.
// - Generates active-low hs/vs with 1020 pixels per line and 312 lines per field.
// - Exposes h/v counters so the AY-3-8500 core can render its objects.
// - Merges the object flags (score, ball, left/right paddle, field) into 4:4:4 RGB using fixed priority and a palette.
// PARAMETERS
// - H_TOTAL      1020  pixels per line (clk cycles); must be <= 1024 (scandoubler buffer limit)
// - H_SYNC_START 0     hcnt value at which hs falls; this marks the line start for the downstream stage
// - H_SYNC_LEN   75    hs low width in clk cycles (4.7 us at 15.9375 MHz)
// - H_ACT_START  192   first visible pixel
// - H_ACT_END    960   first pixel after the visible region
// - V_TOTAL      312   lines per field
// - V_SYNC_LEN   3     vs low width in lines, starting at vcnt 0
// - V_ACT_START  40    first visible line
// - V_ACT_END    296   first line after the visible region
// PORTS
// - clk        in   1   pixel clock, 15.9375 MHz (same clock as scandoubler "clk")
// - rst        in   1   synchronous reset, active-high
// - palette    in   2   0 = B/W, 1 = green field, 2 = blue field, 3 = inverted B/W
// - obj_score  in   1   score digit pixel, aligned to hcnt/vcnt
// - obj_ball   in   1   ball pixel
// - obj_lpad   in   1   left paddle pixel
// - obj_rpad   in   1   right paddle pixel
// - obj_field  in   1   court lines / net pixel
// - hcnt       out  10  current pixel within the line, 0..H_TOTAL-1
// - vcnt       out  9   current line, 0..V_TOTAL-1
// - line_start out  1   1-cycle pulse when hcnt==0
// - hs_out     out  1   horizontal sync, active low
// - vs_out     out  1   vertical sync, active low
// - blank      out  1   high outside the active window
// - r_out      out  4   red
// - g_out      out  4   green
// - b_out      out  4   blue
// BEHAVIOUR
// - Reset state: hcnt = 0, vcnt = 0, line_start = 0, hs_out = 1, vs_out = 1, blank = 1, rgb = 0.
//   - rst asserted mid-line wins over every other update and restarts the raster at the next cycle.
// - hcnt increments every clk and wraps H_TOTAL-1 -> 0.
//   - vcnt increments only on that wrap and wraps V_TOTAL-1 -> 0 on the same edge.
//   - No other count value is ever reachable.
// - Pipeline: objects and counters are sampled at stage 0.
//   - hs_out, vs_out, blank and rgb are all registered, with exactly 1 cycle of latency from the hcnt value that produced them.
//   - Every output shares this one-cycle delay, so sync and pixels stay mutually aligned.
// - hs_out = 0 for hcnt in [H_SYNC_START, H_SYNC_START+H_SYNC_LEN); 1 otherwise.
// - vs_out = 0 for vcnt in [0, V_SYNC_LEN).
//   - vs edges occur only at the hs falling edge (hcnt == 0), never mid-line.
// - blank = !(hcnt in [H_ACT_START, H_ACT_END) && vcnt in [V_ACT_START, V_ACT_END)).
// - Colour select, highest priority first: score > ball > lpad > rpad > field > background.
//   - Simultaneous flags resolve strictly by this order.
// - Palette (foreground / background, 12-bit RGB):
//   - 0: FFF / 000
//   - 1: objects FFF, background 060
//   - 2: objects FFF, background 008
//   - 3: objects 000, background FFF
//   - Paddles use the foreground colour, except in palette 1, where lpad = F80 and rpad = 0FF.
// - blank forces rgb = 000 regardless of objects or palette.
// - line_start: registered, asserted in the cycle where hs_out first goes 0.
// - palette changes take effect on the next pixel; no glitch suppression is needed.
// STRUCTURE
// - Package ay_video_pkg holds the timing constants above and the palette localparams PAL_BW, PAL_GREEN, PAL_BLUE, PAL_INV.
//   - It also holds the 12-bit colour constants.
// - Sub-module ay_raster_counter: hcnt/vcnt counters plus the wrap logic.
//   - This top module adds the sync/blank decode and the colour mixer.
// TESTING
// - Reset: hold rst 5 cycles, then release.
//   - Required: hcnt 0 -> 1 on the first clk after release.
//   - Required: hs_out is 1 during reset and falls 1 cycle after hcnt==0.
// - Free run for 2 fields.
//   - Required: hs period = 1020 cycles, hs low = 75.
//   - Required: vs low = 3*1020 cycles, field = 318240 cycles.
//   - Required: vs edges coincide with hs falling edges.
// - Drive obj_ball = 1 at hcnt = 500, vcnt = 100 with palette 0.
//   - Required: rgb = FFF exactly 1 cycle later, and 000 the cycle after.
// - All obj_* = 1 at the same pixel with palette 1.
//   - Required: score colour FFF wins.
//   - Then drop score and ball: lpad colour F80 wins over rpad and field.
// - obj_field = 1 at hcnt = 100 (blanked region), palette 3.
//   - Required: rgb = 000 and blank = 1.
//   - At hcnt = 500 with no objects: rgb = FFF.
// - Assert rst at hcnt = 700, vcnt = 150.
//   - Required: the next cycle shows hcnt = 0, vcnt = 0, hs_out = 1, vs_out = 1, rgb = 000.

Source files
------------

// File: rtl/ay_video_pkg.sv
// Timing, palette and colour constants for the PAL 15 kHz raster and colour mixer,
// plus the priority/palette colour helper shared by the mixer.
package ay_video_pkg;

  localparam logic [9:0] H_TOTAL      = 10'd1020;
  localparam logic [9:0] H_SYNC_START = 10'd0;
  localparam logic [9:0] H_SYNC_LEN   = 10'd75;
  localparam logic [9:0] H_ACT_START  = 10'd192;
  localparam logic [9:0] H_ACT_END    = 10'd960;

  localparam logic [8:0] V_TOTAL      = 9'd312;
  localparam logic [8:0] V_SYNC_LEN   = 9'd3;
  localparam logic [8:0] V_ACT_START  = 9'd40;
  localparam logic [8:0] V_ACT_END    = 9'd296;

  localparam logic [1:0] PAL_BW    = 2'd0;
  localparam logic [1:0] PAL_GREEN = 2'd1;
  localparam logic [1:0] PAL_BLUE  = 2'd2;
  localparam logic [1:0] PAL_INV   = 2'd3;

  localparam logic [11:0] RGB_WHITE  = 12'hFFF;
  localparam logic [11:0] RGB_BLACK  = 12'h000;
  localparam logic [11:0] RGB_GREEN  = 12'h060;
  localparam logic [11:0] RGB_BLUE   = 12'h008;
  localparam logic [11:0] RGB_ORANGE = 12'hF80;
  localparam logic [11:0] RGB_CYAN   = 12'h0FF;

  // Priority: score > ball > lpad > rpad > field > background.
  function automatic logic [11:0] mix_colour(
    input logic [1:0] palette,
    input logic       score,
    input logic       ball,
    input logic       lpad,
    input logic       rpad,
    input logic       field
  );
    logic [11:0] fg;
    logic [11:0] bg;
    logic [11:0] lpad_c;
    logic [11:0] rpad_c;
    fg = RGB_WHITE;
    bg = RGB_BLACK;
    case (palette)
      PAL_BW:    bg = RGB_BLACK;
      PAL_GREEN: bg = RGB_GREEN;
      PAL_BLUE:  bg = RGB_BLUE;
      PAL_INV: begin
        fg = RGB_BLACK;
        bg = RGB_WHITE;
      end
      default:   bg = RGB_BLACK;
    endcase
    lpad_c = (palette == PAL_GREEN) ? RGB_ORANGE : fg;
    rpad_c = (palette == PAL_GREEN) ? RGB_CYAN : fg;
    if (score || ball) begin
      mix_colour = fg;
    end else if (lpad) begin
      mix_colour = lpad_c;
    end else if (rpad) begin
      mix_colour = rpad_c;
    end else if (field) begin
      mix_colour = fg;
    end else begin
      mix_colour = bg;
    end
  endfunction

endpackage

// File: rtl/ay_raster_counter.sv
// Free-running pixel/line counters for one PAL field; vcnt steps only on the hcnt wrap.
module ay_raster_counter
  import ay_video_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] hcnt,
  output logic [8:0] vcnt
);

  // Pixel and line counters with wrap at the end of line / end of field.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= 10'd0;
      vcnt <= 9'd0;
    end else if (hcnt == H_TOTAL - 10'd1) begin
      hcnt <= 10'd0;
      vcnt <= (vcnt == V_TOTAL - 9'd1) ? 9'd0 : vcnt + 9'd1;
    end else begin
      hcnt <= hcnt + 10'd1;
      vcnt <= vcnt;
    end
  end

endmodule

// File: rtl/ay_video_timing.sv
// PAL raster generator: counters, sync/blank decode and priority colour mixer.
// All sync, blank and colour outputs are registered one cycle after the counter value.
module ay_video_timing
  import ay_video_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] palette,
  input  logic       obj_score,
  input  logic       obj_ball,
  input  logic       obj_lpad,
  input  logic       obj_rpad,
  input  logic       obj_field,
  output logic [9:0] hcnt,
  output logic [8:0] vcnt,
  output logic       line_start,
  output logic       hs_out,
  output logic       vs_out,
  output logic       blank,
  output logic [3:0] r_out,
  output logic [3:0] g_out,
  output logic [3:0] b_out
);

  logic [9:0]  h_rel_s;
  logic        hs_s;
  logic        vs_s;
  logic        blank_s;
  logic        start_s;
  logic [11:0] rgb_s;

  ay_raster_counter u_counter (
    .clk  (clk),
    .rst  (rst),
    .hcnt (hcnt),
    .vcnt (vcnt)
  );

  // Stage-0 decode of sync, blank and pixel colour from the current counters.
  always_comb begin
    h_rel_s = hcnt - H_SYNC_START;
    hs_s    = !(h_rel_s < H_SYNC_LEN);
    vs_s    = !(vcnt < V_SYNC_LEN);
    start_s = (hcnt == H_SYNC_START);
    blank_s = !((hcnt >= H_ACT_START) && (hcnt < H_ACT_END) &&
                (vcnt >= V_ACT_START) && (vcnt < V_ACT_END));
    if (blank_s) begin
      rgb_s = RGB_BLACK;
    end else begin
      rgb_s = mix_colour(palette, obj_score, obj_ball, obj_lpad, obj_rpad, obj_field);
    end
  end

  // Output register stage keeping sync and pixels aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_start <= 1'b0;
      hs_out     <= 1'b1;
      vs_out     <= 1'b1;
      blank      <= 1'b1;
      r_out      <= 4'd0;
      g_out      <= 4'd0;
      b_out      <= 4'd0;
    end else begin
      line_start <= start_s;
      hs_out     <= hs_s;
      vs_out     <= vs_s;
      blank      <= blank_s;
      r_out      <= rgb_s[11:8];
      g_out      <= rgb_s[7:4];
      b_out      <= rgb_s[3:0];
    end
  end

endmodule
